// File: rtl/alu_core.sv
// Byte-serial 16-bit ALU with context register and programmable result framing.
// Optional DIV on opcode 7 is enabled by defining ALU_DIV_EN.
module alu_core #(
  parameter int CTX_W = 8
) (
  input  logic             tb_clk,
  input  logic             tb_rst_n,
  input  logic             alu_ctl,
  input  logic [7:0]       alu_dat,
  input  logic [CTX_W-1:0] ctx_in,
  input  logic             ctx_val,
  input  logic [4:0]       frame_len,
  input  logic             frame_len_val,
  output logic [CTX_W-1:0] ctx_out,
  output logic             alu_ready,
  output logic [31:0]      alu_result,
  output logic             frame,
  output logic             frame_bp,
  output logic [31:0]      frame_data
);

  typedef enum logic [2:0] {IDLE, A_HI, A_LO, B_HI, B_LO} state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [15:0]      a_q;
  logic [7:0]       b_hi_q;
  logic             alu_ready_q;
  logic [31:0]      alu_result_q;
  logic [CTX_W-1:0] ctx_q;

  logic [4:0]       len_q, pend_q, pend_d, cnt_q;
  logic             frame_q, frame_bp_q;
  logic [31:0]      frame_data_q;

  logic [15:0]      b_full;
  logic [31:0]      a32, b32, res_d;
  logic             done, word, last;

  // The B_LO byte is consumed straight off the bus so the result is ready one edge later.
  assign b_full = {b_hi_q, alu_dat};
  assign a32    = {16'h0000, a_q};
  assign b32    = {16'h0000, b_full};
  assign done   = (state_q == B_LO) && !alu_ctl;

  always_comb begin
    res_d = '0;
    unique case (op_q)
      3'd0: res_d = a32 + b32;
      3'd1: res_d = a32 - b32;
      3'd2: res_d = a32 * b32;
      3'd3: res_d = a32 & b32;
      3'd4: res_d = a32 | b32;
      3'd5: res_d = a32 ^ b32;
      3'd6: res_d = a32 << b_full[4:0];
      3'd7: begin
`ifdef ALU_DIV_EN
        if (b_full == 16'h0000) res_d = '1;
        else                    res_d = {a_q % b_full, a_q / b_full};
`else
        res_d = '0;
`endif
      end
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge tb_clk or posedge tb_rst_n) begin
    if (tb_rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_hi_q       <= '0;
      alu_ready_q  <= 1'b0;
      alu_result_q <= '0;
    end else begin
      alu_ready_q <= done;
      if (done) alu_result_q <= res_d;
      if (alu_ctl) begin
        // An opcode beat in any state starts a fresh command, abandoning a partial one.
        op_q    <= alu_dat[2:0];
        state_q <= A_HI;
      end else begin
        unique case (state_q)
          IDLE:    state_q <= IDLE;
          A_HI:    begin a_q[15:8] <= alu_dat; state_q <= A_LO; end
          A_LO:    begin a_q[7:0]  <= alu_dat; state_q <= B_HI; end
          B_HI:    begin b_hi_q    <= alu_dat; state_q <= B_LO; end
          B_LO:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge tb_clk or posedge tb_rst_n) begin
    if (tb_rst_n) ctx_q <= '0;
    else if (ctx_val) ctx_q <= ctx_in;
  end

  assign pend_d = frame_len_val ? frame_len : pend_q;
  assign word   = done && (len_q != 5'd0);
  assign last   = word && ((cnt_q + 5'd1) == len_q);

  always_ff @(posedge tb_clk or posedge tb_rst_n) begin
    if (tb_rst_n) begin
      pend_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      frame_q      <= 1'b0;
      frame_bp_q   <= 1'b0;
      frame_data_q <= '0;
    end else begin
      pend_q     <= pend_d;
      frame_bp_q <= last;
      // Length only changes at a frame boundary, so an in-flight frame keeps its size.
      if ((cnt_q == 5'd0) && !word) len_q <= pend_d;
      if (word) begin
        frame_data_q <= res_d;
        frame_q      <= 1'b1;
        cnt_q        <= last ? 5'd0 : cnt_q + 5'd1;
      end else begin
        if (cnt_q == 5'd0) frame_q <= 1'b0;
        if (len_q == 5'd0) frame_data_q <= '0;
      end
    end
  end

  assign ctx_out    = ctx_q;
  assign alu_ready  = alu_ready_q;
  assign alu_result = alu_result_q;
  assign frame      = frame_q;
  assign frame_bp   = frame_bp_q;
  assign frame_data = frame_data_q;

endmodule

// File: tb/tb_alu_core.sv
// Randomized self-checking bench for alu_core against an arithmetic reference model.
module tb_alu_core;

  logic        tb_clk = 1'b0;
  logic        tb_rst_n = 1'b1;
  logic        alu_ctl = 1'b0;
  logic [7:0]  alu_dat = '0;
  logic [7:0]  ctx_in = '0;
  logic        ctx_val = 1'b0;
  logic [4:0]  frame_len = '0;
  logic        frame_len_val = 1'b0;
  logic [7:0]  ctx_out;
  logic        alu_ready;
  logic [31:0] alu_result;
  logic        frame;
  logic        frame_bp;
  logic [31:0] frame_data;

  always #5 tb_clk = ~tb_clk;

  alu_core #(.CTX_W(8)) dut (
    .tb_clk(tb_clk), .tb_rst_n(tb_rst_n), .alu_ctl(alu_ctl), .alu_dat(alu_dat),
    .ctx_in(ctx_in), .ctx_val(ctx_val), .frame_len(frame_len), .frame_len_val(frame_len_val),
    .ctx_out(ctx_out), .alu_ready(alu_ready), .alu_result(alu_result),
    .frame(frame), .frame_bp(frame_bp), .frame_data(frame_data)
  );

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int exp_pulses = 0;

  // Reference state: active/pending frame length, words in current frame, context.
  int         m_len = 0, m_pend = 0, m_cnt = 0;
  logic [7:0] m_ctx = '0;
  logic       ctx_req = 1'b0;
  logic [7:0] ctx_req_val = '0;

  always @(negedge tb_clk) if (alu_ready === 1'b1) pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input int a, input int b);
    longint unsigned la = longint'(a);
    longint unsigned lb = longint'(b);
    longint unsigned r;
    case (op)
      0: r = la + lb;
      1: r = la - lb;
      2: r = la * lb;
      3: r = la & lb;
      4: r = la | lb;
      5: r = la ^ lb;
      6: r = la << (lb % 32);
`ifdef ALU_DIV_EN
      7: r = (lb == 0) ? 64'hFFFF_FFFF : (((la % lb) << 16) | (la / lb));
`else
      7: r = 0;
`endif
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic beat(input logic ctl, input logic [7:0] d);
    @(posedge tb_clk); #1;
    alu_ctl = ctl;
    alu_dat = d;
    ctx_val = ctx_req;
    ctx_in  = ctx_req ? ctx_req_val : 8'($urandom);
    if (ctx_req) m_ctx = ctx_req_val;
    ctx_req = 1'b0;
  endtask

  task automatic run_cmd(input int op, input int a, input int b);
    logic [31:0] r;
    logic [7:0]  opb;
    logic [15:0] av, bv;
    logic        ef, ebp;
    logic [31:0] ed;
    r   = ref_alu(op, a, b);
    av  = 16'(a);
    bv  = 16'(b);
    opb = 8'($urandom);
    opb[2:0] = 3'(op);
    beat(1'b1, opb);
    beat(1'b0, av[15:8]);
    beat(1'b0, av[7:0]);
    beat(1'b0, bv[15:8]);
    beat(1'b0, bv[7:0]);
    beat(1'b0, 8'h00);
    @(negedge tb_clk);
    exp_pulses++;
    if (m_cnt == 0) m_len = m_pend;
    if (m_len > 0) begin
      m_cnt++;
      ef  = 1'b1;
      ebp = (m_cnt == m_len);
      ed  = r;
      if (ebp) m_cnt = 0;
    end else begin
      ef = 1'b0; ebp = 1'b0; ed = '0;
    end
    check_eq("ready", 32'(alu_ready), 32'd1);
    check_eq("result", alu_result, r);
    check_eq("frame_on_word", 32'(frame), 32'(ef));
    check_eq("frame_bp_on_word", 32'(frame_bp), 32'(ebp));
    check_eq("frame_data", frame_data, ed);
    @(negedge tb_clk);
    check_eq("ready_pulse_end", 32'(alu_ready), 32'd0);
    check_eq("frame_bp_end", 32'(frame_bp), 32'd0);
    check_eq("frame_after", 32'(frame), 32'((m_len > 0) && (m_cnt != 0)));
    check_eq("ctx_out", 32'(ctx_out), 32'(m_ctx));
  endtask

  task automatic set_len(input int l);
    @(posedge tb_clk); #1;
    frame_len_val = 1'b1;
    frame_len     = 5'(l);
    @(posedge tb_clk); #1;
    frame_len_val = 1'b0;
    frame_len     = 5'($urandom);
    m_pend = l;
  endtask

  task automatic abort_cmd(input int k);
    beat(1'b1, 8'($urandom));
    for (int i = 0; i < k; i++) beat(1'b0, 8'($urandom));
    @(negedge tb_clk);
    check_eq("abort_noready", 32'(alu_ready), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge tb_clk); #1;
    alu_ctl  = 1'b0;
    tb_rst_n = 1'b1;
    #2;
    check_eq("rst_ctx", 32'(ctx_out), 32'd0);
    check_eq("rst_ready", 32'(alu_ready), 32'd0);
    check_eq("rst_result", alu_result, 32'd0);
    check_eq("rst_frame", 32'(frame), 32'd0);
    check_eq("rst_bp", 32'(frame_bp), 32'd0);
    check_eq("rst_fdata", frame_data, 32'd0);
    @(posedge tb_clk); #1;
    tb_rst_n = 1'b0;
    m_len = 0; m_pend = 0; m_cnt = 0; m_ctx = '0;
  endtask

  function automatic int rand_opnd();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 65535;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge tb_clk);
    do_reset();

    run_cmd(0, 16'h1234, 16'h0011);
    run_cmd(1, 1, 2);
    run_cmd(2, 16'hFFFF, 16'hFFFF);
    run_cmd(6, 1, 16'h001F);
    run_cmd(5, 16'hF0F0, 16'h0FF0);

    abort_cmd(2);
    run_cmd(0, 1, 1);

    set_len(3);
    for (int i = 0; i < 4; i++) run_cmd(0, i, 100);
    set_len(0);
    run_cmd(0, 7, 8);
    run_cmd(0, 9, 10);

    set_len(3);
    run_cmd(4, 16'h00F0, 16'h000F);
    set_len(2);
    for (int i = 0; i < 4; i++) run_cmd(3, 16'hFFFF, i + 1);

    @(posedge tb_clk); #1;
    ctx_val = 1'b1; ctx_in = 8'hA5;
    @(posedge tb_clk); #1;
    ctx_val = 1'b0; ctx_in = 8'h5A;
    m_ctx = 8'hA5;
    @(negedge tb_clk);
    check_eq("ctx_load", 32'(ctx_out), 32'h000000A5);
    @(negedge tb_clk);
    check_eq("ctx_hold", 32'(ctx_out), 32'h000000A5);

    ctx_req = 1'b1; ctx_req_val = 8'h3C;
    run_cmd(2, 300, 200);

    beat(1'b1, 8'h00);
    beat(1'b0, 8'h12);
    beat(1'b0, 8'h34);
    do_reset();
    run_cmd(0, 16'h1234, 16'h0011);

    run_cmd(7, 100, 7);
    run_cmd(7, 5, 0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 19))
        0, 1: set_len(int'($urandom_range(0, 4)));
        2, 3: abort_cmd(int'($urandom_range(0, 3)));
        4: begin
          ctx_req = 1'b1;
          ctx_req_val = 8'($urandom);
          run_cmd(int'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
        end
        default: run_cmd(int'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
      endcase
    end

    repeat (3) @(negedge tb_clk);
    check_eq("pulse_count", 32'(pulses), 32'(exp_pulses));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
Byte-serial 16-bit ALU with a context register and a result-framing stream. A command is one opcode beat followed by four operand bytes on an 8-bit bus. The block returns a registered 32-bit result with a one-cycle ready pulse. Each result is also forwarded on a framed output stream whose length is programmable. Sits behind a testbench or host wrapper that drives the command bus and context interface.

Parameters:
CTX_W, 8, width of context in/out bus (only 8 is verified)

Ports:
tb_clk  input  1  clock, all state on rising edge
tb_rst_n  input  1  reset, asynchronous, active-high
alu_ctl  input  1  marks the opcode beat of a command
alu_dat  input  8  opcode byte or operand byte
ctx_in  input  CTX_W  context value
ctx_val  input  1  load ctx_in into context register
frame_len  input  5  words per frame (0 = framing disabled)
frame_len_val  input  1  load frame_len
ctx_out  output  CTX_W  context register
alu_ready  output  1  one-cycle result-valid pulse
alu_result  output  32  result, holds until next result
frame  output  1  frame-active indicator
frame_bp  output  1  pulse on last word of a frame
frame_data  output  32  frame word, holds between words

Behaviour:
- Reset (tb_rst_n=1, async): FSM to IDLE. All outputs 0. Frame length register 0. Frame word counter 0. Operand registers 0.
- FSM states: IDLE -> A_HI -> A_LO -> B_HI -> B_LO -> IDLE.
- IDLE: alu_ctl=1 latches opcode=alu_dat[2:0] and goes to A_HI; alu_dat[7:3] ignored. alu_ctl=0 in IDLE means the bus is idle.
- Operand beats are on consecutive cycles with no gaps: A[15:8], A[7:0], B[15:8], B[7:0].
- alu_ctl=1 during any operand state aborts the current command; that beat is a new opcode beat (go to A_HI). No result is produced for the aborted command.
- The next command's opcode beat may come in the cycle after B_LO (back-to-back commands).
- Latency: B_LO byte sampled at edge N. alu_result updated and alu_ready=1 for the cycle after edge N. alu_ready=0 otherwise.
- Opcodes (A, B unsigned 16-bit; result 32-bit):
  - 0 ADD: A+B, zero-extended.
  - 1 SUB: A-B, as 32-bit two's complement (sign-extended borrow).
  - 2 MUL: A*B.
  - 3 AND, 4 OR, 5 XOR: zero-extended.
  - 6 SHL: {16'b0,A} << B[4:0].
  - 7: see Optional Feature.
- Context: ctx_val=1 registers ctx_in into ctx_out on the next edge. ctx_out holds otherwise. Independent of the ALU FSM.
- Frame length: frame_len_val=1 loads frame_len into a pending register. The pending value is applied only when the word counter is 0 (frame boundary); while the counter is 0 it takes effect immediately. A load mid-frame never alters the current frame.
- Framing, active length L>0:
  - On each alu_ready, frame_data is set to alu_result in the same cycle and the counter increments.
  - frame=1 from the first word of a frame through the last word inclusive, including idle cycles between words.
  - frame_bp=1 for exactly one cycle, coincident with word L; the counter then wraps to 0 and frame drops the following cycle unless a new word arrives.
- L=0: frame, frame_bp and frame_data stay 0.
- Simultaneous ctx_val and a command: both take effect independently.

Optional Feature:
ALU_DIV_EN:
- Defined: opcode 7 = DIV, result {A%B, A/B} (remainder in [31:16], quotient in [15:0]). B=0 gives 32'hFFFF_FFFF. Same latency as the other opcodes.
- Undefined: opcode 7 gives alu_result=0 with the normal alu_ready pulse.

Test Plan:
- ADD 0x1234+0x0011 -> alu_ready one cycle after last byte, alu_result=0x00001245. Then SUB 0x0001-0x0002 -> 0xFFFFFFFF.
- MUL 0xFFFF*0xFFFF -> 0xFFFE0001. SHL A=0x0001, B=0x001F -> 0x80000000. XOR 0xF0F0^0x0FF0 -> 0x0000FF00.
- Opcode beat, 2 operand bytes, then new opcode (ADD 1+1) -> only one alu_ready, alu_result=0x00000002.
- frame_len=3, then 3 ADD commands -> frame high from word 1 through word 3, frame_bp only on word 3. A 4th result starts a new frame. frame_len=0 -> frame stays 0.
- ctx_val with ctx_in=0xA5 -> ctx_out=0xA5 next cycle. ctx_in=0x5A with ctx_val=0 -> ctx_out stays 0xA5. Reset asserted mid-command -> all outputs 0, FSM IDLE, next full command computes correctly.
- With ALU_DIV_EN: DIV 100/7 -> 0x0002000E. DIV 5/0 -> 0xFFFFFFFF. Without it: opcode 7 -> 0.
